fpnew_rob_issuer: RTL and testbench



---
 rtl/fpnew_rob_issuer.sv | 162 ++++++++++++++++
 tb/tb_fpnew_rob_issuer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_rob_issuer.sv
// Core-side FPU initiator: tags each issued op with a ROB slot, collects out-of-order
// results and hands them back to the core strictly in issue order.
module fpnew_rob_issuer #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 4,
    parameter int unsigned TagW  = $clog2(Depth),
    // Defaults match the fpnew_pkg encodings; pass the fpnew_pkg types when integrating.
    parameter type roundmode_e  = logic [2:0],
    parameter type operation_e  = logic [3:0],
    parameter type fp_format_e  = logic [2:0],
    parameter type int_format_e = logic [1:0],
    parameter type status_t     = logic [4:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [2:0][Width-1:0]      req_operands_i,
    input  roundmode_e                 req_rnd_mode_i,
    input  operation_e                 req_op_i,
    input  logic                       req_op_mod_i,
    input  fp_format_e                 req_src_fmt_i,
    input  fp_format_e                 req_dst_fmt_i,
    input  int_format_e                req_int_fmt_i,
    input  logic                       req_vectorial_i,
    output logic [2:0][Width-1:0]      fpu_operands_o,
    output roundmode_e                 fpu_rnd_mode_o,
    output operation_e                 fpu_op_o,
    output logic                       fpu_op_mod_o,
    output fp_format_e                 fpu_src_fmt_o,
    output fp_format_e                 fpu_dst_fmt_o,
    output int_format_e                fpu_int_fmt_o,
    output logic                       fpu_vectorial_o,
    output logic [TagW-1:0]            fpu_tag_o,
    output logic                       fpu_in_valid_o,
    input  logic                       fpu_in_ready_i,
    output logic                       fpu_flush_o,
    input  logic                       fpu_out_valid_i,
    output logic                       fpu_out_ready_o,
    input  logic [Width-1:0]           fpu_result_i,
    input  status_t                    fpu_status_i,
    input  logic [TagW-1:0]            fpu_tag_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [Width-1:0]           rsp_result_o,
    output status_t                    rsp_status_o,
    output logic                       busy_o,
    output logic                       tag_err_o
);

    localparam int unsigned CntW = TagW + 1;

    logic [Depth-1:0] pending_reg;
    logic [Depth-1:0] done_reg;
    logic [Width-1:0] result_reg [Depth];
    status_t          status_reg [Depth];
    logic [TagW-1:0]  head_reg;
    logic [TagW-1:0]  tail_reg;
    logic [CntW-1:0]  count_reg;
    logic             tag_err_reg;

    logic             full;
    logic             alloc;
    logic             wb_fire;
    logic             wb_hit;
    logic             retire;
    logic [Depth-1:0] alloc_sel;
    logic [Depth-1:0] wb_sel;
    logic [Depth-1:0] retire_sel;

    assign fpu_operands_o  = req_operands_i;
    assign fpu_rnd_mode_o  = req_rnd_mode_i;
    assign fpu_op_o        = req_op_i;
    assign fpu_op_mod_o    = req_op_mod_i;
    assign fpu_src_fmt_o   = req_src_fmt_i;
    assign fpu_dst_fmt_o   = req_dst_fmt_i;
    assign fpu_int_fmt_o   = req_int_fmt_i;
    assign fpu_vectorial_o = req_vectorial_i;
    assign fpu_tag_o       = tail_reg;
    assign fpu_flush_o     = flush_i | rst_i;

    // The FPU's ready may depend on its valid, so valid must not look at ready.
    assign full            = (count_reg == CntW'(Depth));
    assign fpu_in_valid_o  = req_valid_i & ~full & ~flush_i;
    assign req_ready_o     = fpu_in_valid_o & fpu_in_ready_i;
    assign alloc           = req_ready_o;

    // A slot is reserved at issue, so results can always be absorbed.
    assign fpu_out_ready_o = ~flush_i;
    assign wb_fire         = fpu_out_valid_i & fpu_out_ready_o;
    assign wb_hit          = wb_fire & pending_reg[fpu_tag_i] & ~done_reg[fpu_tag_i];

    assign rsp_valid_o     = done_reg[head_reg];
    assign rsp_result_o    = result_reg[head_reg];
    assign rsp_status_o    = status_reg[head_reg];
    assign retire          = rsp_valid_o & rsp_ready_i;

    assign busy_o          = (count_reg != '0);
    assign tag_err_o       = tag_err_reg;

    for (genvar gi = 0; gi < Depth; gi++) begin : gen_sel
        assign alloc_sel[gi]  = alloc  & (tail_reg  == TagW'(gi));
        assign wb_sel[gi]     = wb_hit & (fpu_tag_i == TagW'(gi));
        assign retire_sel[gi] = retire & (head_reg  == TagW'(gi));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            pending_reg <= '0;
            done_reg    <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
        end else begin
            // Alloc, writeback and retire never target the same slot in one cycle.
            for (int i = 0; i < Depth; i++) begin
                if (alloc_sel[i]) begin
                    pending_reg[i] <= 1'b1;
                    done_reg[i]    <= 1'b0;
                end else if (wb_sel[i]) begin
                    done_reg[i]    <= 1'b1;
                end else if (retire_sel[i]) begin
                    pending_reg[i] <= 1'b0;
                    done_reg[i]    <= 1'b0;
                end
            end
            if (alloc) begin
                tail_reg <= tail_reg + TagW'(1);
            end
            if (retire) begin
                head_reg <= head_reg + TagW'(1);
            end
            case ({alloc, retire})
                2'b10:   count_reg <= count_reg + CntW'(1);
                2'b01:   count_reg <= count_reg - CntW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_err_reg <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                result_reg[i] <= '0;
                status_reg[i] <= '0;
            end
        end else begin
            if (wb_fire && !wb_hit) begin
                tag_err_reg <= 1'b1;
            end
            for (int i = 0; i < Depth; i++) begin
                if (wb_sel[i]) begin
                    result_reg[i] <= fpu_result_i;
                    status_reg[i] <= fpu_status_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpnew_rob_issuer.sv
// Bench for fpnew_rob_issuer: directed vector table, hand sequences, and random traffic
// checked against a queue-based in-order-return model.
module tb_fpnew_rob_issuer;

    localparam int W  = 64;
    localparam int D  = 4;
    localparam int TW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, flush, req_valid, req_ready;
    logic [2:0][W-1:0]   req_operands, fpu_operands;
    logic [2:0]          req_rnd, fpu_rnd;
    logic [3:0]          req_op, fpu_op;
    logic                req_op_mod, fpu_op_mod;
    logic [2:0]          req_src, fpu_src, req_dst, fpu_dst;
    logic [1:0]          req_intf, fpu_intf;
    logic                req_vec, fpu_vec;
    logic [TW-1:0]       fpu_tag_out, fpu_tag_in;
    logic                fpu_in_valid, fpu_in_ready, fpu_flush;
    logic                fpu_out_valid, fpu_out_ready;
    logic [W-1:0]        fpu_result, rsp_result;
    logic [4:0]          fpu_status, rsp_status;
    logic                rsp_valid, rsp_ready, busy, tag_err;

    fpnew_rob_issuer #(.Width(W), .Depth(D)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operands_i(req_operands), .req_rnd_mode_i(req_rnd), .req_op_i(req_op),
        .req_op_mod_i(req_op_mod), .req_src_fmt_i(req_src), .req_dst_fmt_i(req_dst),
        .req_int_fmt_i(req_intf), .req_vectorial_i(req_vec),
        .fpu_operands_o(fpu_operands), .fpu_rnd_mode_o(fpu_rnd), .fpu_op_o(fpu_op),
        .fpu_op_mod_o(fpu_op_mod), .fpu_src_fmt_o(fpu_src), .fpu_dst_fmt_o(fpu_dst),
        .fpu_int_fmt_o(fpu_intf), .fpu_vectorial_o(fpu_vec),
        .fpu_tag_o(fpu_tag_out), .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
        .fpu_flush_o(fpu_flush), .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
        .busy_o(busy), .tag_err_o(tag_err)
    );

    // Reference model: in-flight ops in issue order.
    typedef struct {
        logic [TW-1:0] tag;
        bit            done;
        logic [W-1:0]  res;
        logic [4:0]    st;
    } op_t;

    op_t q[$];
    int  next_tag = 0;
    bit  m_err = 1'b0;
    int  total = 0;
    int  bad = 0;

    typedef struct {
        int rst, fl, rv, ir, ov, otag, ores, rr;
        int e_rr, e_tag, e_rv, e_res, e_busy, e_err;
    } vec_t;

    vec_t tbl[30];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit v, input bit ir, input bit ov,
                         input logic [TW-1:0] ot, input logic [W-1:0] ores,
                         input logic [4:0] ost, input bit rr);
        rst = r; flush = f; req_valid = v; fpu_in_ready = ir;
        fpu_out_valid = ov; fpu_tag_in = ot; fpu_result = ores; fpu_status = ost;
        rsp_ready = rr;
        for (int k = 0; k < 3; k++) req_operands[k] = {$urandom, $urandom};
        req_rnd = 3'($urandom); req_op = 4'($urandom); req_op_mod = 1'($urandom);
        req_src = 3'($urandom); req_dst = 3'($urandom); req_intf = 2'($urandom);
        req_vec = 1'($urandom);
    endtask

    task automatic model_check();
        bit full, e_iv, e_rr, e_rv;
        #2;
        full = (q.size() == D);
        e_iv = req_valid && !full && !flush;
        e_rr = e_iv && fpu_in_ready;
        e_rv = (q.size() > 0) && q[0].done;
        chk("in_valid", 64'(fpu_in_valid), 64'(e_iv));
        chk("req_ready", 64'(req_ready), 64'(e_rr));
        chk("fpu_tag", 64'(fpu_tag_out), 64'(next_tag));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        if (e_rv) begin
            chk("rsp_result", rsp_result, q[0].res);
            chk("rsp_status", 64'(rsp_status), 64'(q[0].st));
        end
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("tag_err", 64'(tag_err), 64'(m_err));
        chk("fpu_flush", 64'(fpu_flush), 64'(flush | rst));
        chk("out_ready", 64'(fpu_out_ready), 64'(!flush));
        for (int k = 0; k < 3; k++) chk("pass_ops", fpu_operands[k], req_operands[k]);
        chk("pass_fields",
            64'({fpu_rnd, fpu_op, fpu_op_mod, fpu_src, fpu_dst, fpu_intf, fpu_vec}),
            64'({req_rnd, req_op, req_op_mod, req_src, req_dst, req_intf, req_vec}));
    endtask

    task automatic tick();
        bit  acc, ret;
        int  hit;
        op_t e;
        acc = req_valid && (q.size() != D) && !flush && fpu_in_ready;
        ret = (q.size() > 0) && q[0].done && rsp_ready;
        if (rst || flush) begin
            q.delete();
            next_tag = 0;
            if (rst) m_err = 1'b0;
        end else begin
            if (fpu_out_valid) begin
                hit = -1;
                foreach (q[j]) if (q[j].tag == fpu_tag_in && !q[j].done) hit = j;
                if (hit >= 0) begin
                    q[hit].done = 1'b1;
                    q[hit].res  = fpu_result;
                    q[hit].st   = fpu_status;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (ret) void'(q.pop_front());
            if (acc) begin
                e.tag = TW'(next_tag); e.done = 1'b0; e.res = '0; e.st = '0;
                q.push_back(e);
                next_tag = (next_tag + 1) % D;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst fl rv ir ov tag res   rr | rr tag rv res  busy err
        tbl[0]  = '{0, 0, 1, 1, 0, 0, 'h00, 0,  1, 0, 0, 'h00, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 'h00, 0,  0, 1, 0, 'h00, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 'h00, 0,  0, 1, 0, 'h00, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 0, 'h11, 0,  0, 1, 0, 'h00, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 'h00, 1,  0, 1, 1, 'h11, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 'h00, 0,  0, 1, 0, 'h00, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 'h00, 0,  0, 1, 0, 'h00, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 0, 0, 'h00, 0,  1, 0, 0, 'h00, 0, 0};
        tbl[8]  = '{0, 0, 1, 1, 0, 0, 'h00, 0,  1, 1, 0, 'h00, 1, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, 0, 'h00, 0,  1, 2, 0, 'h00, 1, 0};
        tbl[10] = '{0, 0, 1, 1, 0, 0, 'h00, 0,  1, 3, 0, 'h00, 1, 0};
        tbl[11] = '{0, 0, 1, 1, 1, 2, 'h22, 1,  0, 0, 0, 'h00, 1, 0};
        tbl[12] = '{0, 0, 1, 1, 1, 0, 'h20, 1,  0, 0, 0, 'h00, 1, 0};
        tbl[13] = '{0, 0, 1, 1, 1, 3, 'h23, 1,  0, 0, 1, 'h20, 1, 0};
        tbl[14] = '{0, 0, 1, 1, 1, 1, 'h21, 1,  1, 0, 0, 'h00, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 'h00, 1,  0, 1, 1, 'h21, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 'h00, 1,  0, 1, 1, 'h22, 1, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 'h00, 1,  0, 1, 1, 'h23, 1, 0};
        tbl[18] = '{0, 0, 0, 0, 1, 0, 'h30, 1,  0, 1, 0, 'h00, 1, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 'h00, 1,  0, 1, 1, 'h30, 1, 0};
        tbl[20] = '{0, 0, 0, 0, 0, 0, 'h00, 0,  0, 1, 0, 'h00, 0, 0};
        tbl[21] = '{0, 0, 1, 1, 0, 0, 'h00, 0,  1, 1, 0, 'h00, 0, 0};
        tbl[22] = '{0, 0, 1, 1, 1, 1, 'h41, 0,  1, 2, 0, 'h00, 1, 0};
        tbl[23] = '{0, 0, 1, 1, 0, 0, 'h00, 0,  1, 3, 1, 'h41, 1, 0};
        tbl[24] = '{0, 1, 1, 1, 1, 2, 'h42, 0,  0, 0, 1, 'h41, 1, 0};
        tbl[25] = '{0, 0, 0, 0, 0, 0, 'h00, 0,  0, 0, 0, 'h00, 0, 0};
        tbl[26] = '{0, 0, 0, 0, 1, 2, 'h42, 0,  0, 0, 0, 'h00, 0, 0};
        tbl[27] = '{0, 0, 1, 1, 0, 0, 'h00, 0,  1, 0, 0, 'h00, 0, 1};
        tbl[28] = '{1, 0, 0, 0, 0, 0, 'h00, 0,  0, 1, 0, 'h00, 1, 1};
        tbl[29] = '{0, 0, 0, 0, 0, 0, 'h00, 0,  0, 0, 0, 'h00, 0, 0};

        // Power-on reset, then idle-state check.
        drive(1, 0, 0, 0, 0, '0, '0, '0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, '0, '0, '0, 0);
        model_check();
        chk("reset_rsp_result", rsp_result, 64'h0);
        tick();

        // Directed vectors: single op, out-of-order fill, flush, stale response, reset.
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst != 0, tbl[i].fl != 0, tbl[i].rv != 0, tbl[i].ir != 0,
                  tbl[i].ov != 0, TW'(tbl[i].otag), 64'(tbl[i].ores), 5'(tbl[i].ores),
                  tbl[i].rr != 0);
            model_check();
            chk($sformatf("row%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].e_rr));
            chk($sformatf("row%0d_tag", i), 64'(fpu_tag_out), 64'(tbl[i].e_tag));
            chk($sformatf("row%0d_rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].e_rv));
            if (tbl[i].e_rv != 0)
                chk($sformatf("row%0d_rsp_result", i), rsp_result, 64'(tbl[i].e_res));
            chk($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("row%0d_tag_err", i), 64'(tag_err), 64'(tbl[i].e_err));
            $display("row %0d: req_ready=%0b tag=%0d rsp_valid=%0b result=%h busy=%0b tag_err=%0b",
                     i, req_ready, fpu_tag_out, rsp_valid, rsp_result, busy, tag_err);
            tick();
        end

        // Core back-pressure: head result must hold while another writeback lands.
        drive(0, 0, 1, 1, 0, '0, '0, '0, 0);
        model_check();
        tick();
        drive(0, 0, 1, 1, 1, 2'd0, 64'hC0C0_0000_0000_00C0, 5'h15, 0);
        model_check();
        tick();
        for (int s = 0; s < 5; s++) begin
            drive(0, 0, 0, 0, s == 1, 2'd1, 64'h0000_0000_0000_00C1, 5'h0A, 0);
            model_check();
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_result", rsp_result, 64'hC0C0_0000_0000_00C0);
            chk("stall_status", 64'(rsp_status), 64'h15);
            $display("stall %0d: rsp_valid=%0b result=%h status=%h", s, rsp_valid, rsp_result, rsp_status);
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            drive(0, 0, 0, 0, 0, '0, '0, '0, 1);
            model_check();
            tick();
        end
        drive(0, 0, 0, 0, 0, '0, '0, '0, 0);
        model_check();
        chk("stall_drained_busy", 64'(busy), 64'd0);
        tick();

        // Back-to-back issue/retire, FPU latency 1, 20 ops wrap the pointers.
        begin
            logic [TW-1:0] prev_tag;
            bit            prev_v;
            int            nret;
            prev_tag = '0;
            prev_v   = 1'b0;
            nret     = 0;
            for (int k = 0; k < 22; k++) begin
                bit            v, nv;
                logic [TW-1:0] nt;
                v = (k < 20);
                drive(0, 0, v, 1, prev_v, prev_tag, 64'hB000 + 64'(k), 5'(k), 1);
                model_check();
                if (rsp_valid) nret++;
                $display("b2b %0d: tag=%0d req_ready=%0b rsp_valid=%0b result=%h",
                         k, fpu_tag_out, req_ready, rsp_valid, rsp_result);
                nv = v && (q.size() != D);
                nt = TW'(next_tag);
                tick();
                prev_v   = nv;
                prev_tag = nt;
            end
            chk("b2b_retired", 64'(nret), 64'd20);
        end

        // Random traffic with rare flushes, resets and bogus tags.
        for (int n = 0; n < 600; n++) begin
            bit            r, f, v, ir, ov, rr;
            logic [TW-1:0] ot;
            int            cand[$];
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            ov = 1'b0;
            ot = '0;
            foreach (q[j]) if (!q[j].done) cand.push_back(int'(q[j].tag));
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                ov = 1'b1;
                ot = TW'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 31) == 0) begin
                ov = 1'b1;
                ot = TW'($urandom);
            end
            drive(r, f, v, ir, ov, ot, {$urandom, $urandom}, 5'($urandom), rr);
            model_check();
            $display("rnd %0d: rst=%0b flush=%0b req_ready=%0b tag=%0d wb=%0b/%0d rsp_valid=%0b result=%h tag_err=%0b",
                     n, r, f, req_ready, fpu_tag_out, ov, ot, rsp_valid, rsp_result, tag_err);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
